pipelined_cla_adder: RTL and testbench

//  Parametrised W-bit two-level carry-lookahead adder/subtractor with a 1..3-stage pipeline
//  and a valid/ready handshake with backpressure. Successor to the combinational lookahead

---
 rtl/cla_pkg.sv | 29 ++
 rtl/cla_group_carry.sv | 39 +++
 rtl/pipelined_cla_adder.sv | 212 +++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and operand preparation for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ADDC = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // Widest operand prep_operand can handle; callers zero-extend b to this width.
    localparam int CLA_MAX_W = 256;

    // Returns {b', cin}; the reserved opcode behaves as a plain add.
    function automatic logic [CLA_MAX_W:0] prep_operand(
        input op_e                  op,
        input logic [CLA_MAX_W-1:0] b,
        input logic                 c_in
    );
        logic [CLA_MAX_W:0] res;
        case (op)
            OP_SUB:  res = {~b, 1'b1};
            OP_ADDC: res = {b, c_in};
            default: res = {b, 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cla_group_carry.sv
// Combinational lookahead cell: per-position carries plus group generate/propagate
// over M bit (or group) positions.
module cla_group_carry
    import cla_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] g,
    input  logic [M-1:0] p,
    input  logic         cin,
    output logic [M-1:0] c,
    output logic         gg,
    output logic         pg
);

    logic [M-1:0] gen_pre_s;
    logic [M-1:0] prop_pre_s;

    // Prefix generate/propagate from position 0 upward; c[i] = G[i:0] | P[i:0] & cin
    always_comb begin
        logic acc_g;
        logic acc_p;
        gen_pre_s  = {M{1'b0}};
        prop_pre_s = {M{1'b0}};
        acc_g      = 1'b0;
        acc_p      = 1'b1;
        for (int i = 0; i < M; i++) begin
            acc_g         = g[i] | (p[i] & acc_g);
            acc_p         = p[i] & acc_p;
            gen_pre_s[i]  = acc_g;
            prop_pre_s[i] = acc_p;
        end
    end

    assign c  = gen_pre_s | (prop_pre_s & {M{cin}});
    assign gg = gen_pre_s[M-1];
    assign pg = prop_pre_s[M-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-level carry-lookahead adder/subtractor, 1..3 pipeline stages, valid/ready flow control.
// Optional saturation (sat port) is enabled by defining CLA_SAT_EN.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             c_in,
    input  logic [TAG_W-1:0] tag_in,
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic             c_out,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    localparam int G = W / N;

    if ((W % N) != 0 || (W / N) < 2) begin : g_bad_w
        $error("pipelined_cla_adder: W must be a multiple of N with W/N >= 2");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("pipelined_cla_adder: STAGES must be 1, 2 or 3");
    end
    if (W >= CLA_MAX_W) begin : g_bad_max
        $error("pipelined_cla_adder: W exceeds cla_pkg::CLA_MAX_W");
    end

    logic en_s;
    logic sat_in_s;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

`ifdef CLA_SAT_EN
    assign sat_in_s = sat;
`else
    assign sat_in_s = 1'b0;
`endif

    logic             x_valid_s, x_cin_s, x_sat_s;
    logic [1:0]       x_op_s;
    logic [W-1:0]     x_a_s, x_b_s;
    logic [TAG_W-1:0] x_tag_s;

    if (STAGES == 3) begin : g_in_reg
        logic             valid_r, cin_r, sat_r;
        logic [1:0]       op_r;
        logic [W-1:0]     a_r, b_r;
        logic [TAG_W-1:0] tag_r;

        // Input register: decouples the source's wiring from the first lookahead level
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                cin_r   <= 1'b0;
                sat_r   <= 1'b0;
                op_r    <= 2'd0;
                a_r     <= {W{1'b0}};
                b_r     <= {W{1'b0}};
                tag_r   <= {TAG_W{1'b0}};
            end else if (en_s) begin
                valid_r <= in_valid;
                cin_r   <= c_in;
                sat_r   <= sat_in_s;
                op_r    <= op;
                a_r     <= a;
                b_r     <= b;
                tag_r   <= tag_in;
            end
        end

        assign {x_valid_s, x_cin_s, x_sat_s, x_op_s, x_a_s, x_b_s, x_tag_s} =
               {valid_r, cin_r, sat_r, op_r, a_r, b_r, tag_r};
    end else begin : g_in_pass
        assign {x_valid_s, x_cin_s, x_sat_s, x_op_s, x_a_s, x_b_s, x_tag_s} =
               {in_valid, c_in, sat_in_s, op, a, b, tag_in};
    end

    logic [CLA_MAX_W:0]       prep_s;
    logic [CLA_MAX_W-W-1:0]   prep_unused_s;
    logic [W-1:0]             b_prep_s, g_s, p_s, c0_s;
    logic                     cin_s;
    logic [G-1:0]             gg_s, pg_s;

    assign prep_s        = prep_operand(op_e'(x_op_s), {{(CLA_MAX_W-W){1'b0}}, x_b_s}, x_cin_s);
    assign b_prep_s      = prep_s[W:1];
    assign cin_s         = prep_s[0];
    assign prep_unused_s = prep_s[CLA_MAX_W:W+1];
    assign g_s           = x_a_s & b_prep_s;
    assign p_s           = x_a_s ^ b_prep_s;

    // Level 1 runs with a zero group carry-in; the real one is folded in after level 2.
    for (genvar k = 0; k < G; k++) begin : g_lvl1
        cla_group_carry #(.M(N)) u_lvl1 (
            .g   (g_s[k*N +: N]),
            .p   (p_s[k*N +: N]),
            .cin (1'b0),
            .c   (c0_s[k*N +: N]),
            .gg  (gg_s[k]),
            .pg  (pg_s[k])
        );
    end

    logic             y_valid_s, y_cin_s, y_amsb_s, y_sat_s;
    logic [W-1:0]     y_p_s, y_c0_s;
    logic [G-1:0]     y_gg_s, y_pg_s;
    logic [TAG_W-1:0] y_tag_s;

    if (STAGES >= 2) begin : g_mid_reg
        logic             valid_r, cin_r, amsb_r, sat_r;
        logic [W-1:0]     p_r, c0_r;
        logic [G-1:0]     gg_r, pg_r;
        logic [TAG_W-1:0] tag_r;

        // Mid register: cut after bit g/p and group GG/PG
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                cin_r   <= 1'b0;
                amsb_r  <= 1'b0;
                sat_r   <= 1'b0;
                p_r     <= {W{1'b0}};
                c0_r    <= {W{1'b0}};
                gg_r    <= {G{1'b0}};
                pg_r    <= {G{1'b0}};
                tag_r   <= {TAG_W{1'b0}};
            end else if (en_s) begin
                valid_r <= x_valid_s;
                cin_r   <= cin_s;
                amsb_r  <= x_a_s[W-1];
                sat_r   <= x_sat_s;
                p_r     <= p_s;
                c0_r    <= c0_s;
                gg_r    <= gg_s;
                pg_r    <= pg_s;
                tag_r   <= x_tag_s;
            end
        end

        assign {y_valid_s, y_cin_s, y_amsb_s, y_sat_s, y_p_s, y_c0_s, y_gg_s, y_pg_s, y_tag_s} =
               {valid_r, cin_r, amsb_r, sat_r, p_r, c0_r, gg_r, pg_r, tag_r};
    end else begin : g_mid_pass
        assign {y_valid_s, y_cin_s, y_amsb_s, y_sat_s, y_p_s, y_c0_s, y_gg_s, y_pg_s, y_tag_s} =
               {x_valid_s, cin_s, x_a_s[W-1], x_sat_s, p_s, c0_s, gg_s, pg_s, x_tag_s};
    end

    logic [G-1:0] c2_s, gcin_s;
    logic         lvl2_gg_unused_s, lvl2_pg_unused_s;
    logic [W-1:0] carry_s, sum_raw_s, sum_res_s;
    logic         ovf_s;

    cla_group_carry #(.M(G)) u_lvl2 (
        .g   (y_gg_s),
        .p   (y_pg_s),
        .cin (y_cin_s),
        .c   (c2_s),
        .gg  (lvl2_gg_unused_s),
        .pg  (lvl2_pg_unused_s)
    );

    assign gcin_s = {c2_s[G-2:0], y_cin_s};

    for (genvar i = 0; i < W; i++) begin : g_carry
        localparam int J = i % N;
        assign carry_s[i] = y_c0_s[i] | ((&y_p_s[i-J +: J+1]) & gcin_s[i/N]);
    end

    assign sum_raw_s = y_p_s ^ {carry_s[W-2:0], y_cin_s};
    assign ovf_s     = carry_s[W-1] ^ carry_s[W-2];

    // Saturate toward the sign of a when requested and the signed result overflowed
    always_comb begin
        if (y_sat_s && ovf_s) begin
            sum_res_s = y_amsb_s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_res_s = sum_raw_s;
        end
    end

    // Output register: everything the consumer sees is registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= {W{1'b0}};
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            tag_out   <= {TAG_W{1'b0}};
        end else if (en_s) begin
            out_valid <= y_valid_s;
            sum       <= sum_res_s;
            c_out     <= c2_s[G-1];
            ovf       <= ovf_s;
            tag_out   <= y_tag_s;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised self-checking bench for pipelined_cla_adder against an arithmetic reference model.
module tb_pipelined_cla_adder #(
    parameter int W      = 32,
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
);

    typedef struct {
        logic [W-1:0]     sum;
        logic             c;
        logic             v;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    logic             clk, rst_n, in_valid, in_ready, c_in, sat;
    logic             out_valid, out_ready, c_out, ovf;
    logic [1:0]       op;
    logic [W-1:0]     a, b, sum;
    logic [TAG_W-1:0] tag_in, tag_out;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   popped = 0;
    int   rdy_mode = 0;
    logic lat_mode = 1'b0;
    exp_t q[$];

    pipelined_cla_adder #(.W(W), .N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .tag_in    (tag_in),
`ifdef CLA_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on widened operands
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic [TAG_W-1:0] tg, input logic st);
        exp_t e;
        logic [W:0] wide;
        logic signed [W+1:0] sa, sb, sr;
        logic sat_eff;
        sa = {{2{av[W-1]}}, av};
        sb = {{2{bv[W-1]}}, bv};
        case (o)
            2'd1: begin
                wide = {1'b0, av - bv};
                wide[W] = (av >= bv);
                sr = sa - sb;
            end
            2'd2: begin
                wide = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
                sr = sa + sb + {{(W+1){1'b0}}, ci};
            end
            default: begin
                wide = {1'b0, av} + {1'b0, bv};
                sr = sa + sb;
            end
        endcase
        e.sum = wide[W-1:0];
        e.c   = wide[W];
        e.v   = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
        e.tag = tg;
        e.cyc = 0;
`ifdef CLA_SAT_EN
        sat_eff = st;
`else
        sat_eff = 1'b0;
`endif
        if (sat_eff && e.v) e.sum = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 9))
            0: return {W{1'b1}};
            1: return {W{1'b0}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    // out_ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random, other never ready
    initial begin
        int k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (k % 3 == 0); k++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshakes observed at negedge complete on the following posedge
    initial begin
        exp_t e;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_sum = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                check_eq("in_ready", in_ready, !out_valid || out_ready);
                if (prev_stall) begin
                    check_eq("hold_valid", out_valid, 1'b1);
                    check_eq("hold_sum", sum, prev_sum);
                    check_eq("hold_tag", tag_out, prev_tag);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check_eq("spurious_out", out_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check_eq("sum", sum, e.sum);
                        check_eq("c_out", c_out, e.c);
                        check_eq("ovf", ovf, e.v);
                        check_eq("tag", tag_out, e.tag);
                        if (lat_mode) check_eq("latency", cyc - e.cyc, STAGES);
                        popped++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_sum = sum;
                prev_tag = tag_out;
                if (in_valid && in_ready) begin
                    e = model(op, a, b, c_in, tag_in, sat);
                    e.cyc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Called and returns at posedge+1; holds inputs until accepted
    task automatic send(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [TAG_W-1:0] tg, input logic st);
        int n = 0;
        op = o; a = av; b = bv; c_in = ci; tag_in = tg; sat = st; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check_eq("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(nm, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string nm, input logic [1:0] o, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic ci, input logic st,
                           input logic [W-1:0] es, input logic ec, input logic ev);
        int n = 0;
        send(o, av, bv, ci, TAG_W'(n + 5), st);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check_eq({nm, "_lat"}, n, STAGES);
        check_eq({nm, "_sum"}, sum, es);
        check_eq({nm, "_c"}, c_out, ec);
        check_eq({nm, "_ovf"}, ovf, ev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; a = '0; b = '0; c_in = 1'b0; tag_in = '0; sat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_sum", sum, {W{1'b0}});
        check_eq("rst_cout", c_out, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_tag", tag_out, {TAG_W{1'b0}});
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;

        lat_mode = 1'b1;
        rdy_mode = 0;
        run_one("add_wrap", 2'd0, {W{1'b1}}, W'(1), 1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        run_one("add_ovf", 2'd0, {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        run_one("sub_neg", 2'd1, W'(5), W'(7), 1'b0, 1'b0, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
        run_one("sub_eq", 2'd1, W'(7), W'(7), 1'b1, 1'b0, {W{1'b0}}, 1'b1, 1'b0);
        run_one("addc", 2'd2, W'(0), W'(0), 1'b1, 1'b0, W'(1), 1'b0, 1'b0);
        run_one("rsvd", 2'd3, W'(3), W'(4), 1'b1, 1'b0, W'(7), 1'b0, 1'b0);
`ifdef CLA_SAT_EN
        run_one("sat_pos", 2'd0, {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b1, {1'b0, {(W-1){1'b1}}}, 1'b0, 1'b1);
        run_one("sat_neg", 2'd1, {1'b1, {(W-1){1'b0}}}, W'(1), 1'b0, 1'b1, {1'b1, {(W-1){1'b0}}}, 1'b1, 1'b1);
`endif
        wait_empty("directed_drain");

        lat_mode = 1'b0;
        rdy_mode = 1;
        popped = 0;
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)), TAG_W'(i), 1'b0);
        wait_empty("bp_drain");
        check_eq("bp_count", popped, 8);

        rdy_mode = 0;
        lat_mode = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            send(2'($urandom_range(0, 3)), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)),
                 TAG_W'($urandom()), 1'($urandom_range(0, 1)));
        end
        wait_empty("rand_ready_drain");

        lat_mode = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            send(2'($urandom_range(0, 3)), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)),
                 TAG_W'($urandom()), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        wait_empty("rand_bp_drain");

        rdy_mode = 3;
        @(posedge clk); #1;
        op = 2'd0; a = rnd_w(); b = rnd_w(); tag_in = TAG_W'(10); in_valid = 1'b1;
        @(posedge clk); #1;
        a = rnd_w(); tag_in = TAG_W'(11);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_sum", sum, {W{1'b0}});
        check_eq("mid_rst_cout", c_out, 1'b0);
        check_eq("mid_rst_ovf", ovf, 1'b0);
        check_eq("mid_rst_tag", tag_out, {TAG_W{1'b0}});
        repeat (6) begin
            @(negedge clk);
            check_eq("mid_rst_flush", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_one("post_rst", 2'd0, W'(2), W'(3), 1'b0, 1'b0, W'(5), 1'b0, 1'b0);
        wait_empty("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
